// File: rtl/bonus_pool.sv
// rtl/bonus_pool.sv - bonus slot pool: spawn allocation, frame aging, catch reporting
// Slots cycle FREE -> PENDING -> ACTIVE -> FREE; catches are queued per slot and reported lowest index first.
module bonus_pool #(
  parameter int NUM_SLOTS   = 16,
  parameter int CODE_W      = 3,
  parameter int LIFE_FRAMES = 255
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic [CODE_W-1:0]                   bonusCode,
  input  logic [NUM_SLOTS-1:0]                bonusCollision,
  input  logic [NUM_SLOTS-1:0]                slotDone,
  input  logic                                clearAll,
  output logic [NUM_SLOTS-1:0]                activate,
  output logic [NUM_SLOTS-1:0][CODE_W-1:0]    slotCode,
  output logic                                caughtValid,
  output logic [CODE_W-1:0]                   caughtCode,
  output logic                                poolFull,
  output logic [$clog2(NUM_SLOTS+1)-1:0]      activeCount,
  output logic [7:0]                          dropCount
);

  localparam int         CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam logic [8:0] LIFE9  = 9'(LIFE_FRAMES);

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_PEND = 2'd1,
    S_ACT  = 2'd2
  } slot_state_e;

  slot_state_e          state_q [NUM_SLOTS];
  slot_state_e          state_d [NUM_SLOTS];
  logic [7:0]           age_q   [NUM_SLOTS];
  logic [7:0]           age_d   [NUM_SLOTS];
  logic [CODE_W-1:0]    code_q  [NUM_SLOTS];
  logic [CODE_W-1:0]    code_d  [NUM_SLOTS];
  logic [CODE_W-1:0]    ccode_q [NUM_SLOTS];
  logic [CODE_W-1:0]    ccode_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pend_q, pend_d;
  logic [CODE_W-1:0]    prev_code_q, prev_code_d;
  logic                 caught_valid_q, caught_valid_d;
  logic [CODE_W-1:0]    caught_code_q, caught_code_d;
  logic                 pool_full_q, pool_full_d;
  logic [CNT_W-1:0]     active_count_q, active_count_d;
  logic [7:0]           drop_q, drop_d;

  logic request;
  logic alloc_found;
  logic rep_found;
  logic any_free_d;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      code_d[i]  = code_q[i];
      ccode_d[i] = ccode_q[i];
    end
    pend_d         = pend_q;
    prev_code_d    = bonusCode;
    caught_valid_d = 1'b0;
    caught_code_d  = caught_code_q;
    drop_d         = drop_q;
    alloc_found    = 1'b0;
    rep_found      = 1'b0;
    any_free_d     = 1'b0;
    active_count_d = '0;

    request = (bonusCode != '0) && (prev_code_q == '0);

    // Report the lowest pending catch; new catches below are OR-ed in afterwards.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!rep_found && pend_q[i]) begin
        rep_found      = 1'b1;
        pend_d[i]      = 1'b0;
        caught_valid_d = 1'b1;
        caught_code_d  = ccode_q[i];
      end
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      case (state_q[i])
        S_FREE: begin
          if (request && !alloc_found) begin
            alloc_found = 1'b1;
            state_d[i]  = S_PEND;
            code_d[i]   = bonusCode;
          end
        end
        S_PEND: begin
          if (startOfFrame) begin
            state_d[i] = S_ACT;
            age_d[i]   = 8'd0;
          end
        end
        S_ACT: begin
          if (bonusCollision[i]) begin
            state_d[i] = S_FREE;
            age_d[i]   = 8'd0;
            pend_d[i]  = 1'b1;
            ccode_d[i] = code_q[i];
          end else if (slotDone[i]) begin
            state_d[i] = S_FREE;
            age_d[i]   = 8'd0;
          end else if (startOfFrame) begin
            if (({1'b0, age_q[i]} + 9'd1) >= LIFE9) begin
              state_d[i] = S_FREE;
              age_d[i]   = 8'd0;
            end else begin
              age_d[i] = age_q[i] + 8'd1;
            end
          end
        end
        default: state_d[i] = S_FREE;
      endcase
    end

    if (request && !alloc_found && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    if (clearAll) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_d[i] = S_FREE;
        age_d[i]   = 8'd0;
      end
      pend_d         = '0;
      caught_valid_d = 1'b0;
    end

    // Status flags track next-state so the registered outputs line up with state_q.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_d[i] == S_FREE) begin
        any_free_d = 1'b1;
      end else begin
        active_count_d = active_count_d + CNT_W'(1);
      end
    end
    pool_full_d = !any_free_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_FREE;
        age_q[i]   <= 8'd0;
        code_q[i]  <= '0;
        ccode_q[i] <= '0;
      end
      pend_q         <= '0;
      prev_code_q    <= '0;
      caught_valid_q <= 1'b0;
      caught_code_q  <= '0;
      pool_full_q    <= 1'b0;
      active_count_q <= '0;
      drop_q         <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
        code_q[i]  <= code_d[i];
        ccode_q[i] <= ccode_d[i];
      end
      pend_q         <= pend_d;
      prev_code_q    <= prev_code_d;
      caught_valid_q <= caught_valid_d;
      caught_code_q  <= caught_code_d;
      pool_full_q    <= pool_full_d;
      active_count_q <= active_count_d;
      drop_q         <= drop_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      activate[i] = (state_q[i] == S_ACT);
      slotCode[i] = code_q[i];
    end
  end

  assign caughtValid = caught_valid_q;
  assign caughtCode  = caught_code_q;
  assign poolFull    = pool_full_q;
  assign activeCount = active_count_q;
  assign dropCount   = drop_q;

endmodule

// File: tb/tb_bonus_pool.sv
// tb/tb_bonus_pool.sv - directed bench for bonus_pool with a slot-level reference model
// Model advances on each clock edge from the same inputs; outputs are compared on the falling edge.
module tb_bonus_pool;

  localparam int N    = 16;
  localparam int CW   = 3;
  localparam int LIFE = 3;

  logic                 clk = 1'b0;
  logic                 resetN = 1'b0;
  logic                 startOfFrame = 1'b0;
  logic [CW-1:0]        bonusCode = '0;
  logic [N-1:0]         bonusCollision = '0;
  logic [N-1:0]         slotDone = '0;
  logic                 clearAll = 1'b0;
  logic [N-1:0]         activate;
  logic [N-1:0][CW-1:0] slotCode;
  logic                 caughtValid;
  logic [CW-1:0]        caughtCode;
  logic                 poolFull;
  logic [4:0]           activeCount;
  logic [7:0]           dropCount;

  bonus_pool #(.NUM_SLOTS(N), .CODE_W(CW), .LIFE_FRAMES(LIFE)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .bonusCode(bonusCode),
    .bonusCollision(bonusCollision), .slotDone(slotDone), .clearAll(clearAll),
    .activate(activate), .slotCode(slotCode), .caughtValid(caughtValid),
    .caughtCode(caughtCode), .poolFull(poolFull), .activeCount(activeCount),
    .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = free, 1 = waiting for a frame, 2 = on screen.
  int m_state [N];
  int m_age   [N];
  int m_code  [N];
  int m_ccode [N];
  bit m_pend  [N];
  int m_prev = 0;
  int m_cv   = 0;
  int m_cc   = 0;
  int m_drop = 0;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_age[i] = 0; m_code[i] = 0; m_ccode[i] = 0; m_pend[i] = 0;
    end
    m_prev = 0; m_cv = 0; m_cc = 0; m_drop = 0;
  endtask

  task automatic m_step();
    int ns[N]; int na[N]; int nc[N]; int ncc[N]; bit np[N];
    int free_idx; int rep; bit req;
    req = (bonusCode != 0) && (m_prev == 0);
    free_idx = -1;
    for (int i = N - 1; i >= 0; i--) if (m_state[i] == 0) free_idx = i;
    rep = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) rep = i;
    for (int i = 0; i < N; i++) begin
      ns[i] = m_state[i]; na[i] = m_age[i]; nc[i] = m_code[i]; ncc[i] = m_ccode[i]; np[i] = m_pend[i];
    end
    if (rep >= 0) begin
      np[rep] = 0; m_cv = 1; m_cc = m_ccode[rep];
    end else begin
      m_cv = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_state[i] == 0 && req && i == free_idx) begin
        ns[i] = 1; nc[i] = int'(bonusCode);
      end else if (m_state[i] == 1 && startOfFrame) begin
        ns[i] = 2; na[i] = 0;
      end else if (m_state[i] == 2) begin
        if (bonusCollision[i]) begin
          ns[i] = 0; np[i] = 1; ncc[i] = m_code[i];
        end else if (slotDone[i]) begin
          ns[i] = 0;
        end else if (startOfFrame) begin
          if (m_age[i] + 1 >= LIFE) begin ns[i] = 0; na[i] = 0; end
          else na[i] = m_age[i] + 1;
        end
      end
    end
    if (req && free_idx < 0 && m_drop < 255) m_drop++;
    if (clearAll) begin
      for (int i = 0; i < N; i++) begin ns[i] = 0; na[i] = 0; np[i] = 0; end
      m_cv = 0;
    end
    m_prev = int'(bonusCode);
    for (int i = 0; i < N; i++) begin
      m_state[i] = ns[i]; m_age[i] = na[i]; m_code[i] = nc[i]; m_ccode[i] = ncc[i]; m_pend[i] = np[i];
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] e_act;
      logic [N*CW-1:0] e_code;
      int e_cnt;
      e_cnt = 0;
      for (int i = 0; i < N; i++) begin
        e_act[i] = (m_state[i] == 2);
        e_code[i*CW +: CW] = m_code[i][CW-1:0];
        if (m_state[i] != 0) e_cnt++;
      end
      chk("activate", longint'(activate), longint'(e_act));
      chk("slotCode", longint'(slotCode), longint'(e_code));
      chk("caughtValid", longint'(caughtValid), longint'(m_cv));
      if (m_cv != 0) chk("caughtCode", longint'(caughtCode), longint'(m_cc));
      chk("activeCount", longint'(activeCount), longint'(e_cnt));
      chk("poolFull", longint'(poolFull), longint'(e_cnt == N));
      chk("dropCount", longint'(dropCount), longint'(m_drop));
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(int code);
    bonusCode = CW'(code);
    tick(1);
    bonusCode = '0;
    tick(1);
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
  endtask

  initial begin
    int exp_v[5];
    int exp_c[5];

    tick(2);
    resetN = 1'b1;
    cmp_en = 1'b1;
    chk("reset_activate", activate, 0);
    chk("reset_count", activeCount, 0);
    chk("reset_full", poolFull, 0);
    chk("reset_drop", dropCount, 0);

    // Held nonzero code yields a single request.
    bonusCode = 3'd3;
    tick(10);
    bonusCode = '0;
    chk("held_pending_act", activate, 0);
    chk("held_count", activeCount, 1);
    chk("held_code0", slotCode[0], 3);
    sof_pulse();
    chk("held_active", activate, 16'h0001);
    chk("held_count2", activeCount, 1);
    slotDone = 16'h0001;
    tick(1);
    slotDone = '0;
    chk("done_free", activeCount, 0);

    // Fill the pool and overflow by one.
    for (int k = 1; k <= 17; k++) begin
      request(5);
      if (k == 16) begin
        chk("fill_full", poolFull, 1);
        chk("fill_count", activeCount, 16);
        chk("fill_drop0", dropCount, 0);
      end
    end
    chk("over_drop", dropCount, 1);
    chk("over_full", poolFull, 1);
    clearAll = 1'b1;
    tick(1);
    clearAll = 1'b0;
    chk("clear_count", activeCount, 0);
    chk("clear_drop_kept", dropCount, 1);

    // Frame pulse in the allocation cycle must not promote that slot.
    bonusCode = 3'd7;
    startOfFrame = 1'b1;
    tick(1);
    bonusCode = '0;
    startOfFrame = 1'b0;
    chk("sof_same_cycle", activate, 0);
    tick(1);
    for (int s = 1; s <= 9; s++) request(s == 2 ? 1 : s == 5 ? 4 : s == 9 ? 6 : 7);
    sof_pulse();
    chk("ten_active", activate, 16'h03FF);
    slotDone = 16'h01DB;
    tick(1);
    slotDone = '0;
    chk("three_left", activate, 16'h0224);
    bonusCollision = 16'h0224;
    tick(1);
    bonusCollision = '0;
    exp_v = '{0, 1, 1, 1, 0};
    exp_c = '{0, 1, 4, 6, 0};
    for (int j = 0; j < 5; j++) begin
      chk("catch_valid", caughtValid, exp_v[j]);
      if (exp_v[j] != 0) chk("catch_code", caughtCode, exp_c[j]);
      tick(1);
    end
    chk("catch_all_free", activeCount, 0);

    // Lifetime expiry after LIFE frames.
    request(2);
    sof_pulse();
    sof_pulse();
    chk("life_1", activate, 16'h0001);
    sof_pulse();
    chk("life_2", activate, 16'h0001);
    sof_pulse();
    chk("life_expired", activate, 0);
    chk("life_no_catch", caughtValid, 0);

    // Released slot not reusable in its release cycle.
    for (int k = 0; k < 16; k++) request(5);
    sof_pulse();
    chk("e_full_act", activate, 16'hFFFF);
    slotDone = 16'h0001;
    bonusCode = 3'd5;
    tick(1);
    slotDone = '0;
    bonusCode = '0;
    chk("e_drop", dropCount, 2);
    chk("e_count15", activeCount, 15);
    tick(1);
    bonusCode = 3'd2;
    tick(1);
    bonusCode = '0;
    chk("e_reuse_code", slotCode[0], 2);
    chk("e_reuse_full", poolFull, 1);
    chk("e_drop_same", dropCount, 2);

    // clearAll with catches still queued.
    clearAll = 1'b1;
    tick(1);
    clearAll = 1'b0;
    for (int k = 0; k < 8; k++) request(3);
    sof_pulse();
    chk("f_count8", activeCount, 8);
    bonusCollision = 16'h0003;
    tick(1);
    bonusCollision = '0;
    clearAll = 1'b1;
    tick(1);
    clearAll = 1'b0;
    chk("f_count0", activeCount, 0);
    chk("f_act0", activate, 0);
    for (int j = 0; j < 3; j++) begin
      chk("f_no_catch", caughtValid, 0);
      tick(1);
    end

    // Asynchronous reset while a report is on the output.
    for (int k = 0; k < 3; k++) request(4);
    sof_pulse();
    bonusCollision = 16'h0007;
    tick(1);
    bonusCollision = '0;
    tick(1);
    chk("r_catch_live", caughtValid, 1);
    #2 resetN = 1'b0;
    #1;
    chk("r_valid0", caughtValid, 0);
    chk("r_code0", caughtCode, 0);
    chk("r_act0", activate, 0);
    chk("r_count0", activeCount, 0);
    chk("r_drop0", dropCount, 0);
    chk("r_full0", poolFull, 0);
    tick(1);
    resetN = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick(1);
      chk("r_no_residual", caughtValid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
